// File: rtl/jpeg_stream_pkg.sv
// Shared constants and types for the JPEG byte-stream blocks.
package jpeg_stream_pkg;

    localparam int DATA_W      = 8;
    localparam int BLOCK_BYTES = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        ROUTE = 1'b1
    } demux_state_t;

endpackage

// File: rtl/out_stage_reg.sv
// One-entry valid/ready output register. It can accept a new byte when it is
// empty or when its current byte is being drained in the same cycle.
module out_stage_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ready_in,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              ready
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Next-state: a load wins over a drain; data holds unless loaded.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = data_in;
        end else if (valid_q && ready_in) begin
            valid_d = 1'b0;
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign ready = !valid_q || ready_in;

endmodule

// File: rtl/byte_demux_1x2.sv
// Burst-granular 1-to-2 byte demux. The channel is chosen by in_code on the
// first byte of each burst and held for the rest of the burst.
module byte_demux_1x2 #(
    parameter int DATA_W    = jpeg_stream_pkg::DATA_W,
    parameter int BURST_LEN = jpeg_stream_pkg::BLOCK_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_code,
    output logic              in_ready,
    output logic              out0_valid,
    output logic [DATA_W-1:0] out0_data,
    input  logic              out0_ready,
    output logic              out1_valid,
    output logic [DATA_W-1:0] out1_data,
    input  logic              out1_ready,
    output logic              busy,
    output logic              burst_done
);

    import jpeg_stream_pkg::*;

    localparam int               CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BURST_LEN - 1);

    demux_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             done_q, done_d;

    logic tgt;
    logic st0_ready, st1_ready;
    logic xfer;
    logic load0, load1;

    // Target: live code while idle, latched code once a burst is open.
    always_comb begin
        tgt      = (state_q == ROUTE) ? sel_q : in_code;
        in_ready = !rst && (tgt ? st1_ready : st0_ready);
        xfer     = in_valid && in_ready;
        load0    = xfer && !tgt;
        load1    = xfer && tgt;
    end

    // Burst FSM and byte counter; a one-byte burst never leaves IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        if (xfer) begin
            if (state_q == IDLE) begin
                sel_d = in_code;
                if (BURST_LEN == 1) begin
                    done_d = 1'b1;
                end else begin
                    state_d = ROUTE;
                    cnt_d   = CNT_W'(1);
                end
            end else if (cnt_q == LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Control register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
        end
    end

    assign busy       = (state_q == ROUTE);
    assign burst_done = done_q;

    out_stage_reg #(.DATA_W(DATA_W)) u_out0 (
        .clk      (clk),
        .rst      (rst),
        .load     (load0),
        .data_in  (in_data),
        .ready_in (out0_ready),
        .valid    (out0_valid),
        .data     (out0_data),
        .ready    (st0_ready)
    );

    out_stage_reg #(.DATA_W(DATA_W)) u_out1 (
        .clk      (clk),
        .rst      (rst),
        .load     (load1),
        .data_in  (in_data),
        .ready_in (out1_ready),
        .valid    (out1_valid),
        .data     (out1_data),
        .ready    (st1_ready)
    );

endmodule

// File: doc/byte_demux_1x2.md
# byte_demux_1x2

Routes one 8-bit byte stream with valid/ready handshake to one of two output channels, burst by burst. The 1-bit `in_code` sampled on the first byte of each burst selects the channel, and the whole burst follows that choice. It sits upstream of per-channel JPEG stages, for example splitting interleaved 8x8 blocks between two processing lanes. Each output has a one-entry registered stage, so backpressure on one channel never corrupts the other.

## Interface
- `DATA_W`, default 8: byte width.
- `BURST_LEN`, default 64: bytes per burst (one 8x8 block); legal range 1..65535.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `in_valid` input, 1 bit: input byte present.
- `in_data` input, DATA_W bits: input byte.
- `in_code` input, 1 bit: channel select; 0 selects out0, 1 selects out1. Sampled only on the first byte of a burst.
- `in_ready` output, 1 bit: block accepts the byte this cycle.
- `out0_valid` output, 1 bit: channel 0 holds a byte.
- `out0_data` output, DATA_W bits: channel 0 byte.
- `out0_ready` input, 1 bit: channel 0 consumer accepts.
- `out1_valid`, `out1_data`, `out1_ready`: same as the channel 0 ports, for channel 1.
- `busy` output, 1 bit: high while a burst is in progress (state ROUTE).
- `burst_done` output, 1 bit: one-cycle pulse after the last byte of a burst is accepted.

## Operation
**States**
- IDLE: no burst open. The target is `in_code` as presented live.
- ROUTE: a burst is open. The target is `sel_q`, the value latched at burst start.

**Byte transfer**
- A transfer happens when `in_valid && in_ready`.
- `in_ready = !rst && (!outT_valid || outT_ready)`, where T is the current target. The non-target channel's state has no effect on `in_ready`.

**On each transfer**
- `in_data` loads outT's register and `outT_valid` is set.
- `cnt` increments.

**Burst start and end**
- A transfer in IDLE latches `sel_q <= in_code`, sets `cnt` to 1 and moves to ROUTE.
- When BURST_LEN = 1, that first transfer also ends the burst: the state stays IDLE and `burst_done` pulses.
- A transfer in ROUTE with `cnt == BURST_LEN-1` ends the burst: the state returns to IDLE, `cnt` clears to 0, and `burst_done` pulses on the next cycle.

**Output stages**
- Each channel's register drains independently: when `outX_valid && outX_ready`, `outX_valid` clears unless the same cycle loads a new byte into that channel.
- Load and drain in the same cycle: the register takes the new byte and `outX_valid` stays 1.
- `outX_data` holds stable while `outX_valid && !outX_ready`.

**Boundary conditions**
- `in_code` changes inside a burst are ignored.
- Back-to-back bursts may target different channels with no idle cycle.
- The last byte of a burst may still be pending in the previous channel while the next burst fills the other channel.
- `in_valid` low in mid-burst stalls: `cnt` holds and the state holds. There is no timeout.
- `rst` asserted mid-burst aborts the burst. Pending output bytes are discarded and the next byte starts a new burst.

## Timing
- Reset values (the cycle after `rst` is sampled high): state IDLE, `cnt` 0, `sel_q` 0, `out0_valid` 0, `out1_valid` 0, `out0_data` 0, `out1_data` 0, `busy` 0, `burst_done` 0. `in_ready` is 0 during the reset cycle.
- Latency: a byte accepted at edge N appears on `outT_valid`/`outT_data` after edge N, one cycle.
- Throughput: one byte per cycle while the target's ready is held high.
- `busy` is registered. It goes high the cycle after the first transfer and low the cycle after the last transfer, in the same cycle `burst_done` pulses.
- `in_ready` is combinational from `outT_ready`, `outT_valid` and state. There is no combinational path from `in_valid` to `in_ready`.
- `cnt` width is `$clog2(BURST_LEN+1)`; it never exceeds BURST_LEN-1.

## Structure
- Shared package `jpeg_stream_pkg`:
  - `DATA_W` = 8
  - `BLOCK_BYTES` = 64
  - `demux_state_t` enum {IDLE, ROUTE}
- Sub-module `out_stage_reg`: one-entry valid/ready register with `load`, `data_in`, `ready_in`, `valid`, `data`, `ready`. Instantiated twice, once per channel.
- Top level: FSM, counter, `sel_q`, and the target mux for ready/load.

## Test plan
- **Basic routing.** BURST_LEN=4, both outX_ready=1, `in_code`=1, bytes 0x10..0x13 streamed. Required: out1 emits 0x10..0x13 on consecutive cycles and out0_valid never rises. `burst_done` pulses once, one cycle after 0x13 is accepted.
- **Code ignored mid-burst.** `in_code` toggled every cycle during burst 0xA0..0xA3, starting at 0. Required: all four bytes go to out0.
- **Backpressure.** `out0_ready`=0 for 3 cycles after byte 0x55. Required: `in_ready`=0 for those cycles, `out0_data` holds 0x55, and no bytes are lost or duplicated once ready returns.
- **Alternate channels back-to-back.** Burst to out0, then an immediate burst to out1 while out0 still holds its last byte with `out0_ready`=0. Required: out1 fills at full rate and out0's byte is preserved.
- **Reset mid-burst.** `rst` asserted after 2 of 4 bytes. Required: all outputs reach their reset values. The next byte, with `in_code`=1, goes to out1 and the burst completes after 4 new bytes.
- **BURST_LEN=1.** Codes 0,1,1,0 on bytes 0x01..0x04. Required: out0 receives 0x01 and 0x04, out1 receives 0x02 and 0x03, with four `burst_done` pulses.
